// File: rtl/mcp3x02_scanner.sv
// rtl/mcp3x02_scanner.sv - SPI scanner for MCP3002/MCP3202 ADCs with tagged FWFT result FIFO
module mcp3x02_scanner #(
  parameter int CLK_FREQ    = 27_000_000,
  parameter int SCLK_FREQ   = 900_000,
  parameter int SAMPLE_RATE = 48_000,
  parameter int DATA_BITS   = 10,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 auto_en,
  input  logic                 start,
  input  logic [1:0]           mode,
  output logic                 adc_clk,
  output logic                 adc_din,
  input  logic                 adc_dout,
  output logic                 adc_cs,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [7:0]           overrun_cnt,
  input  logic                 overrun_clr
);
  localparam int CYCLE      = CLK_FREQ / SCLK_FREQ;
  localparam int HALF       = CYCLE / 2;
  localparam int N          = DATA_BITS + 5;
  localparam int EDGES      = 2 * N;
  localparam int SAMPLE_DIV = CLK_FREQ / SAMPLE_RATE;
  localparam int HW         = $clog2(HALF + 1);
  localparam int EW         = $clog2(EDGES + 1);
  localparam int GW         = $clog2(CYCLE + 1);
  localparam int TW         = $clog2(SAMPLE_DIV + 1);
  localparam int AW         = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, GUARD} state_t;

  state_t               state;
  logic [HW-1:0]        hcnt;
  logic [EW-1:0]        ecnt;
  logic [GW-1:0]        gcnt;
  logic [TW-1:0]        timer;
  logic                 pending;
  logic                 alt_ch;
  logic                 ch_q;
  logic [1:0]           mode_q;
  logic [DATA_BITS-1:0] sr;
  logic                 tick;
  logic                 push;
  logic                 pop;
  logic                 accept;
  logic                 full;
  logic                 next_ch;

  logic [DATA_BITS-1:0] mem_data [FIFO_DEPTH];
  logic                 mem_ch   [FIFO_DEPTH];
  logic [AW-1:0]        wr_idx;
  logic [AW-1:0]        rd_idx;
  logic [AW:0]          count;

  always_comb begin
    tick    = auto_en && (timer == TW'(SAMPLE_DIV - 1));
    push    = (state == SHIFT) && (hcnt == HW'(HALF - 1)) && (ecnt == EW'(EDGES));
    next_ch = 1'b0;
    case (mode)
      2'b01:   next_ch = 1'b1;
      2'b10:   next_ch = alt_ch;
      default: next_ch = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      adc_cs  <= 1'b1;
      adc_clk <= 1'b0;
      adc_din <= 1'b0;
      busy    <= 1'b0;
      hcnt    <= '0;
      ecnt    <= '0;
      gcnt    <= '0;
      timer   <= '0;
      pending <= 1'b0;
      alt_ch  <= 1'b0;
      ch_q    <= 1'b0;
      mode_q  <= 2'b00;
      sr      <= '0;
    end else begin
      if (!auto_en || tick) timer <= '0;
      else                  timer <= timer + TW'(1);

      // Requests arriving while a frame runs collapse into a single pending flag
      if (state == IDLE && pending) pending <= start | tick;
      else                          pending <= pending | start | tick;

      if (mode != 2'b10)                 alt_ch <= 1'b0;
      else if (push && mode_q == 2'b10)  alt_ch <= ~alt_ch;

      case (state)
        IDLE: begin
          if (pending) begin
            state   <= SHIFT;
            adc_cs  <= 1'b0;
            adc_clk <= 1'b0;
            adc_din <= 1'b1;
            busy    <= 1'b1;
            hcnt    <= '0;
            ecnt    <= '0;
            mode_q  <= mode;
            ch_q    <= (mode == 2'b11) ? 1'b0 : next_ch;
          end
        end
        SHIFT: begin
          if (hcnt == HW'(HALF - 1)) begin
            hcnt <= '0;
            if (ecnt == EW'(EDGES)) begin
              state   <= GUARD;
              adc_cs  <= 1'b1;
              adc_din <= 1'b0;
              gcnt    <= '0;
            end else begin
              adc_clk <= ~adc_clk;
              ecnt    <= ecnt + EW'(1);
              // Even edges rise: data bits follow the start, SGL, ODD, MSBF and null slots
              if (!ecnt[0] && ecnt >= EW'(10)) sr <= {sr[DATA_BITS-2:0], adc_dout};
              if (ecnt == EW'(1))      adc_din <= (mode_q != 2'b11);
              else if (ecnt == EW'(3)) adc_din <= ch_q;
              else if (ecnt == EW'(5)) adc_din <= 1'b1;
              else if (ecnt == EW'(7)) adc_din <= 1'b0;
            end
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        GUARD: begin
          if (gcnt == GW'(CYCLE - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes the new sample when the head leaves in the same cycle
  assign accept    = push && (!full || pop);
  assign out_data  = out_valid ? mem_data[rd_idx] : '0;
  assign out_ch    = out_valid ? mem_ch[rd_idx] : 1'b0;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_data[wr_idx] <= sr;
      mem_ch[wr_idx]   <= ch_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx      <= '0;
      rd_idx      <= '0;
      count       <= '0;
      overrun_cnt <= 8'd0;
    end else begin
      if (accept) wr_idx <= wr_idx + AW'(1);
      if (pop)    rd_idx <= rd_idx + AW'(1);
      if (accept && !pop)      count <= count + (AW+1)'(1);
      else if (!accept && pop) count <= count - (AW+1)'(1);
      if (overrun_clr)                                   overrun_cnt <= 8'd0;
      else if (push && !accept && overrun_cnt != 8'hFF)  overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_mcp3x02_scanner.sv
// tb/tb_mcp3x02_scanner.sv - self-checking bench for mcp3x02_scanner with behavioural ADC and FIFO model
module tb_mcp3x02_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       auto_en = 1'b0, start = 1'b0, out_ready = 1'b1, overrun_clr = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       adc_clk, adc_din, adc_cs, out_ch, out_valid, busy;
  logic       adc_dout = 1'b0;
  logic [9:0] out_data;
  logic [7:0] overrun_cnt;

  logic        auto_en_12 = 1'b0, start_12 = 1'b0, out_ready_12 = 1'b0, overrun_clr_12 = 1'b0;
  logic [1:0]  mode_12 = 2'b00;
  logic        adc_clk_12, adc_din_12, adc_cs_12, out_ch_12, out_valid_12, busy_12;
  logic        adc_dout_12 = 1'b0;
  logic [11:0] out_data_12;
  logic [7:0]  overrun_cnt_12;

  mcp3x02_scanner dut (
    .clk(clk), .rst(rst), .auto_en(auto_en), .start(start), .mode(mode),
    .adc_clk(adc_clk), .adc_din(adc_din), .adc_dout(adc_dout), .adc_cs(adc_cs),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun_cnt(overrun_cnt), .overrun_clr(overrun_clr)
  );

  mcp3x02_scanner #(.DATA_BITS(12)) dut12 (
    .clk(clk), .rst(rst), .auto_en(auto_en_12), .start(start_12), .mode(mode_12),
    .adc_clk(adc_clk_12), .adc_din(adc_din_12), .adc_dout(adc_dout_12), .adc_cs(adc_cs_12),
    .out_data(out_data_12), .out_ch(out_ch_12), .out_valid(out_valid_12), .out_ready(out_ready_12),
    .busy(busy_12), .overrun_cnt(overrun_cnt_12), .overrun_clr(overrun_clr_12)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC models: record the 4 command bits, then shift the chosen value out on falling edges
  int         rc10 = 0;
  logic [3:0] cmd10 = '0;
  logic [9:0] sh10 = '0, v_ch0 = '0, v_ch1 = '0, v_diff = '0;
  always @(negedge adc_cs) begin rc10 = 0; cmd10 = '0; end
  always @(posedge adc_clk) if (!adc_cs) begin
    if (rc10 < 4) cmd10 = {cmd10[2:0], adc_din};
    rc10++;
  end
  always @(negedge adc_clk) if (!adc_cs) begin
    if (rc10 == 4) sh10 = cmd10[2] ? (cmd10[1] ? v_ch1 : v_ch0) : v_diff;
    if (rc10 >= 5 && rc10 <= 14) begin adc_dout = sh10[9]; sh10 = sh10 << 1; end
    else adc_dout = 1'b0;
  end

  int          rc12 = 0;
  logic [3:0]  cmd12 = '0;
  logic [11:0] sh12 = '0, v12 = 12'hABC;
  always @(negedge adc_cs_12) begin rc12 = 0; cmd12 = '0; end
  always @(posedge adc_clk_12) if (!adc_cs_12) begin
    if (rc12 < 4) cmd12 = {cmd12[2:0], adc_din_12};
    rc12++;
  end
  always @(negedge adc_clk_12) if (!adc_cs_12) begin
    if (rc12 == 4) sh12 = v12;
    if (rc12 >= 5 && rc12 <= 16) begin adc_dout_12 = sh12[11]; sh12 = sh12 << 1; end
    else adc_dout_12 = 1'b0;
  end

  // Result model: a 4-entry queue fed by completed frames, drained by accepted handshakes
  logic       cs_prev = 1'b1, busy_prev = 1'b0, fire_prev = 1'b0, clr_prev = 1'b0;
  logic       drop, frame_done;
  logic [9:0] mq_data[$];
  logic       mq_ch[$];
  int         movr = 0;
  int         push_cyc[$];
  logic [9:0] got_data[$];
  logic       got_ch[$];
  int         cs_fall_cyc = 0, busy_fall_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      mq_data.delete(); mq_ch.delete();
      movr = 0; cs_prev = 1'b1; busy_prev = 1'b0; fire_prev = 1'b0; clr_prev = 1'b0;
    end else begin
      drop = 1'b0;
      frame_done = !cs_prev && adc_cs;
      if (cs_prev && !adc_cs) cs_fall_cyc = cyc;
      if (busy_prev && !busy) busy_fall_cyc = cyc;
      if (frame_done) begin
        push_cyc.push_back(cyc);
        check("frame_len", rc10, 15);
        drop = (mq_data.size() == 4) && !fire_prev;
      end
      if (fire_prev && mq_data.size() != 0) begin
        void'(mq_data.pop_front());
        void'(mq_ch.pop_front());
      end
      if (frame_done && !drop) begin
        mq_data.push_back(cmd10[2] ? (cmd10[1] ? v_ch1 : v_ch0) : v_diff);
        mq_ch.push_back(cmd10[2] & cmd10[1]);
      end
      if (clr_prev) movr = 0;
      else if (drop && movr < 255) movr++;
      check("out_valid", out_valid, mq_data.size() != 0);
      if (mq_data.size() != 0) begin
        check("out_data", out_data, mq_data[0]);
        check("out_ch", out_ch, mq_ch[0]);
      end
      check("overrun_cnt", overrun_cnt, movr);
      fire_prev = out_valid && out_ready;
      if (fire_prev) begin got_data.push_back(out_data); got_ch.push_back(out_ch); end
      clr_prev = overrun_clr; cs_prev = adc_cs; busy_prev = busy;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    step(1); start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic wait_push(input int target, input string name);
    int n = 0;
    while (push_cyc.size() < target && n < 3000) begin @(negedge clk); #1; n++; end
    check(name, push_cyc.size() >= target, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin @(negedge clk); #1; n++; end
    check(name, busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int pb, gb, p6, n;
  initial begin
    step(3);
    check("rst_cs", adc_cs, 1);
    check("rst_clk", adc_clk, 0);
    check("rst_din", adc_din, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ch", out_ch, 0);
    check("rst_ovr", overrun_cnt, 0);
    rst = 1'b0;
    step(2);

    // 1: single CH0 conversion
    v_ch0 = 10'h2A5; v_ch1 = 10'h15A; v_diff = 10'h155;
    pb = push_cyc.size(); gb = got_data.size();
    pulse_start();
    wait_push(pb + 1, "t1_push");
    wait_idle("t1_idle");
    if (push_cyc.size() > pb) check("t1_cs_low", push_cyc[pb] - cs_fall_cyc, 465);
    check("t1_busy", busy_fall_cyc - cs_fall_cyc, 495);
    check("t1_cmd", cmd10, 4'b1101);
    if (got_data.size() > gb) begin
      check("t1_data", got_data[gb], 10'h2A5);
      check("t1_ch", got_ch[gb], 0);
    end else check("t1_pop", got_data.size(), gb + 1);

    // 2: alternating auto-trigger
    step(1); mode = 2'b10; v_ch0 = 10'h100; v_ch1 = 10'h3FF;
    pb = push_cyc.size(); gb = got_data.size();
    step(1); auto_en = 1'b1;
    wait_push(pb + 3, "t2_push");
    wait_idle("t2_idle");
    step(1); auto_en = 1'b0; mode = 2'b00;
    step(2);
    if (got_data.size() >= gb + 3 && push_cyc.size() >= pb + 3) begin
      check("t2_ch_a", got_ch[gb], 0);     check("t2_data_a", got_data[gb], 10'h100);
      check("t2_ch_b", got_ch[gb+1], 1);   check("t2_data_b", got_data[gb+1], 10'h3FF);
      check("t2_ch_c", got_ch[gb+2], 0);   check("t2_data_c", got_data[gb+2], 10'h100);
      check("t2_gap_1", push_cyc[pb+1] - push_cyc[pb], 562);
      check("t2_gap_2", push_cyc[pb+2] - push_cyc[pb+1], 562);
    end else check("t2_count", got_data.size(), gb + 3);

    // 3: differential conversion
    step(1); mode = 2'b11;
    pb = push_cyc.size(); gb = got_data.size();
    pulse_start();
    wait_push(pb + 1, "t3_push");
    wait_idle("t3_idle");
    check("t3_cmd", cmd10, 4'b1001);
    if (got_data.size() > gb) begin
      check("t3_ch", got_ch[gb], 0);
      check("t3_data", got_data[gb], 10'h155);
    end else check("t3_pop", got_data.size(), gb + 1);

    // 4: overrun counting and clear-vs-increment priority
    step(1); mode = 2'b00; out_ready = 1'b0; v_ch0 = 10'h0AA;
    pb = push_cyc.size();
    step(1); auto_en = 1'b1;
    wait_push(pb + 4, "t4_push4");
    check("t4_full_valid", out_valid, 1);
    check("t4_ovr0", overrun_cnt, 0);
    wait_push(pb + 5, "t4_push5");
    check("t4_ovr1", overrun_cnt, 1);
    wait_push(pb + 6, "t4_push6");
    check("t4_ovr2", overrun_cnt, 2);
    if (push_cyc.size() >= pb + 6) begin
      p6 = push_cyc[pb+5];
      n = 0;
      while (cyc < p6 + 560 && n < 1000) begin @(negedge clk); n++; end
      @(posedge clk); #1 overrun_clr = 1'b1;
      @(posedge clk); #1 overrun_clr = 1'b0;
      wait_push(pb + 7, "t4_push7");
      check("t4_ovr_clr", overrun_cnt, 0);
      if (push_cyc.size() >= pb + 7) check("t4_clr_aligned", push_cyc[pb+6] - p6, 562);
    end
    step(1); auto_en = 1'b0; out_ready = 1'b1;
    wait_idle("t4_idle");
    step(10);
    check("t4_drained", out_valid, 0);

    // 5: reset in the middle of a frame
    step(1); out_ready = 1'b0; v_ch0 = 10'h0F0;
    pb = push_cyc.size();
    pulse_start();
    wait_push(pb + 1, "t5_push");
    wait_idle("t5_idle");
    check("t5_held", out_valid, 1);
    pulse_start();
    n = 0;
    while (!(!adc_cs && rc10 == 7) && n < 2000) begin @(negedge clk); #1; n++; end
    check("t5_reach_e12", rc10, 7);
    rst = 1'b1;
    #1;
    check("t5_cs_async", adc_cs, 1);
    check("t5_fifo_empty", out_valid, 0);
    check("t5_busy", busy, 0);
    step(2); rst = 1'b0; out_ready = 1'b1;
    step(2);
    pb = push_cyc.size(); gb = got_data.size();
    pulse_start();
    wait_push(pb + 1, "t5_push2");
    wait_idle("t5_idle2");
    if (push_cyc.size() > pb) check("t5_cs_low", push_cyc[pb] - cs_fall_cyc, 465);
    check("t5_cmd", cmd10, 4'b1101);
    if (got_data.size() > gb) check("t5_data", got_data[gb], 10'h0F0);
    else check("t5_pop", got_data.size(), gb + 1);

    // 6: 12-bit instance
    step(1); start_12 = 1'b1; step(1); start_12 = 1'b0;
    n = 0;
    while (adc_cs_12 && n < 100) begin @(negedge clk); #1; n++; end
    n = 0;
    while (!adc_cs_12 && n < 2000) begin n++; @(negedge clk); #1; end
    check("t6_cs_low", n, 525);
    check("t6_sclk_periods", rc12, 17);
    check("t6_cmd", cmd12, 4'b1101);
    check("t6_valid", out_valid_12, 1);
    check("t6_data", out_data_12, 12'hABC);
    check("t6_ch", out_ch_12, 0);

    step(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
